if_fetch_unit: RTL

//  Instruction-fetch stage directly downstream of the 32-bit PC register.

---
 rtl/if_fetch_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage that sits right after the PC register. It issues
//   in-order fetch requests for the current PC, tells the PC register to step
//   to PC+4 whenever a request is accepted, and parks the returned instruction
//   words, tagged with their PCs, in a small circular buffer. Decode drains
//   that buffer over a valid/ready handshake. A flush (branch redirect) throws
//   away everything buffered and marks every in-flight request to be dropped
//   when its response eventually arrives.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : asynchronous, active-low reset (0 = held in reset)
//   pc             : current PC from the PC register
//   pc_advance     : request accepted this cycle, PC register loads PC+4
//   imem_req_valid : fetch request valid
//   imem_req_addr  : word-aligned fetch address derived from pc
//   imem_req_ready : instruction memory accepts the request
//   imem_rsp_valid : in-order response strobe, always accepted
//   imem_rsp_data  : returned instruction word
//   flush          : redirect, discard buffered and outstanding fetches
//   inst_valid     : buffer head holds a returned instruction for decode
//   inst_data      : instruction word at the buffer head
//   inst_pc        : PC of the instruction at the buffer head
//   inst_ready     : decode accepts the head instruction
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_advance,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  input  logic          flush,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Occupancy and request bookkeeping
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

  // head: oldest entry for decode, tail: next entry to allocate,
  // fill: oldest allocated entry still waiting for its response
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [PW-1:0]    fill_q, fill_d;

  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0]    pc_mem_q   [DEPTH];
  logic [AW-1:0]    pc_mem_d   [DEPTH];
  logic [DW-1:0]    data_mem_q [DEPTH];
  logic [DW-1:0]    data_mem_d [DEPTH];

  logic issue;
  logic pop;
  logic rsp_ok;

  // Handshake outputs. Request and decode valids look only at registered
  // occupancy, so a pop in the same cycle never opens up a request slot.
  // Both valids are gated by reset so nothing leaks out while held in reset.
  always_comb begin
    imem_req_addr  = {pc[AW-1:2], 2'b00};
    imem_req_valid = reset & ~flush & (count_q < FULL_C) & (outstanding_q < FULL_C);
    issue          = imem_req_valid & imem_req_ready;
    pc_advance     = issue;

    inst_valid     = reset & ~flush & (count_q != '0) & filled_q[head_q];
    pop            = inst_valid & inst_ready;
    inst_data      = (count_q == '0) ? '0 : data_mem_q[head_q];
    inst_pc        = (count_q == '0) ? '0 : pc_mem_q[head_q];

    // A response with nothing outstanding is a protocol error and is ignored
    rsp_ok         = imem_rsp_valid & (outstanding_q != '0);
  end

  // Next-state logic. Issue, fill and pop always land on different entries:
  // tail is free, fill is allocated but empty, head is filled.
  // On flush every request not yet answered must be dropped, so the drop
  // counter is reloaded with the outstanding requests left after this cycle's
  // response. Reloading (rather than accumulating) keeps back-to-back flushes
  // idempotent, since drop_cnt never exceeds outstanding.
  always_comb begin
    count_d       = count_q;
    drop_cnt_d    = drop_cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fill_d        = fill_q;
    filled_d      = filled_q;
    pc_mem_d      = pc_mem_q;
    data_mem_d    = data_mem_q;
    outstanding_d = outstanding_q + (issue ? CNT_ONE : '0) - (rsp_ok ? CNT_ONE : '0);

    if (flush) begin
      count_d    = '0;
      head_d     = tail_q;
      fill_d     = tail_q;
      filled_d   = '0;
      drop_cnt_d = outstanding_q - (rsp_ok ? CNT_ONE : '0);
    end else begin
      if (issue) begin
        pc_mem_d[tail_q] = pc;
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PTR_ONE;
      end

      if (rsp_ok) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CNT_ONE;
        end else begin
          data_mem_d[fill_q] = imem_rsp_data;
          filled_d[fill_q]   = 1'b1;
          fill_d             = fill_q + PTR_ONE;
        end
      end

      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_ONE;
      end

      count_d = count_q + (issue ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    end
  end

  // State registers; reset clears every counter, pointer and entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fill_q        <= '0;
      filled_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fill_q        <= fill_d;
      filled_q      <= filled_d;
      pc_mem_q      <= pc_mem_d;
      data_mem_q    <= data_mem_d;
    end
  end

  // Memory must never answer a request that was not issued
  rsp_without_request: assert property (
    @(posedge clk) disable iff (!reset) !(imem_rsp_valid && (outstanding_q == '0))
  );

endmodule
